// File: rtl/esl_led_pwm_if.sv
// Control and LED-drive bundle for esl_led_pwm.
// The master side owns the requests; the slave side (the PWM stage) owns the LED pins and the period marker.
interface esl_led_pwm_if #(
    parameter int LED_WIDTH = 8,
    parameter int PWM_BITS  = 8
);
    logic [LED_WIDTH-1:0] led_in;
    logic [PWM_BITS-1:0]  duty_max;
    logic                 fade_en;
    logic [LED_WIDTH-1:0] led_out;
    logic                 period_tick;

    modport master (
        output led_in, duty_max, fade_en,
        input  led_out, period_tick
    );

    modport slave (
        input  led_in, duty_max, fade_en,
        output led_out, period_tick
    );
endinterface

// File: rtl/esl_led_pwm.sv
// PWM LED driver with a bus-set brightness ceiling and an optional per-LED linear fade.
// Define ESL_LED_PWM_GAMMA_EN to square the compare value (gamma correction); it is linear by default.
module esl_led_pwm #(
    parameter int LED_WIDTH = 8,
    parameter int PWM_BITS  = 8,
    parameter int PRESCALE  = 16,
    parameter int FADE_STEP = 8
) (
    input  logic          clk,
    input  logic          reset,
    esl_led_pwm_if.slave  pwm_if
);
    localparam int                PRESC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [PWM_BITS:0]  STEP       = (PWM_BITS + 1)'(FADE_STEP);

    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [PWM_BITS-1:0]  cnt_q, cnt_d;
    logic [PWM_BITS-1:0]  level_q [LED_WIDTH];
    logic [PWM_BITS-1:0]  level_d [LED_WIDTH];
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic                 ptick_q;
    logic                 tick;
    logic                 period_end;

    // One extra bit keeps the step from wrapping before it is clamped to the target.
    function automatic logic [PWM_BITS-1:0] next_level(
        input logic [PWM_BITS-1:0] lvl,
        input logic [PWM_BITS-1:0] tgt,
        input logic                fade
    );
        logic [PWM_BITS:0] l_w;
        logic [PWM_BITS:0] t_w;
        logic [PWM_BITS:0] up_w;
        l_w  = {1'b0, lvl};
        t_w  = {1'b0, tgt};
        up_w = l_w + STEP;
        if (!fade || (l_w == t_w)) begin
            return tgt;
        end else if (l_w < t_w) begin
            return (up_w > t_w) ? tgt : up_w[PWM_BITS-1:0];
        end else begin
            return (l_w >= (t_w + STEP)) ? (lvl - STEP[PWM_BITS-1:0]) : tgt;
        end
    endfunction

    function automatic logic [PWM_BITS-1:0] eff_of(input logic [PWM_BITS-1:0] lvl);
`ifdef ESL_LED_PWM_GAMMA_EN
        logic [2*PWM_BITS-1:0] sq;
        sq = {{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, lvl};
        return sq[2*PWM_BITS-1:PWM_BITS];
`else
        return lvl;
`endif
    endfunction

    always_comb begin
        tick       = (presc_q == PRESC_LAST);
        presc_d    = tick ? '0 : presc_q + 1'b1;
        cnt_d      = tick ? cnt_q + 1'b1 : cnt_q;
        period_end = tick && (&cnt_q);
    end

    // The output is built from next-state counter/levels so that led_out and
    // period_tick both change in the first cycle of the new period.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < LED_WIDTH; i++) begin
            level_d[i] = period_end
                       ? next_level(level_q[i], pwm_if.led_in[i] ? pwm_if.duty_max : '0, pwm_if.fade_en)
                       : level_q[i];
            led_d[i]   = (&level_d[i]) ? 1'b1 : (cnt_d < eff_of(level_d[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            cnt_q   <= '0;
            led_q   <= '0;
            ptick_q <= 1'b0;
            for (int i = 0; i < LED_WIDTH; i++) begin
                level_q[i] <= '0;
            end
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            ptick_q <= period_end;
            for (int i = 0; i < LED_WIDTH; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

    assign pwm_if.led_out     = led_q;
    assign pwm_if.period_tick = ptick_q;
endmodule

// File: tb/tb_esl_led_pwm.sv
// Directed bench for esl_led_pwm: LED_WIDTH=8, PWM_BITS=4, PRESCALE=2, FADE_STEP=4 (32-cycle period).
// Expected high-cycle counts follow the gamma setting of the build (ESL_LED_PWM_GAMMA_EN).
module tb_esl_led_pwm;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    esl_led_pwm_if #(.LED_WIDTH(8), .PWM_BITS(4)) pif ();

    esl_led_pwm #(
        .LED_WIDTH(8), .PWM_BITS(4), .PRESCALE(2), .FADE_STEP(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pwm_if (pif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // High cycles per 32-cycle period for a given level.
    function automatic int exp_hi(input int l);
        int e;
        if (l == 15) return 32;
`ifdef ESL_LED_PWM_GAMMA_EN
        e = (l * l) >> 4;
`else
        e = l;
`endif
        return e * 2;
    endfunction

    // Entered at the negedge of a period_tick cycle; leaves at the next one.
    task automatic run_period(input string tag, input int e0, input int e7,
                              input int t1, input logic [7:0] v1,
                              input int t2, input logic [7:0] v2);
        int h0, h0a, h7, ho;
        h0 = 0; h0a = 0; h7 = 0; ho = 0;
        for (int off = 0; off < 32; off++) begin
            if (off == t1) pif.led_in = v1;
            if (off == t2) pif.led_in = v2;
            if (pif.led_out[0]) begin
                h0++;
                if (off < 16) h0a++;
            end
            if (pif.led_out[7]) h7++;
            if (pif.led_out[6:1] != 6'd0) ho++;
            @(negedge clk);
        end
        check({tag, "_led0"}, h0, e0);
        check({tag, "_led0_front"}, h0a, (e0 < 16) ? e0 : 16);
        check({tag, "_led7"}, h7, e7);
        check({tag, "_led6_1"}, ho, 0);
        check({tag, "_tick"}, pif.period_tick, 1);
    endtask

    initial begin
        int first, nt, bad, hi;
        reset        = 1'b1;
        pif.led_in   = 8'h00;
        pif.duty_max = 4'd0;
        pif.fade_en  = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_led", pif.led_out, 0);
        check("rst_tick", pif.period_tick, 0);
        reset = 1'b0;

        first = -1; nt = 0; bad = 0; hi = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (pif.period_tick) begin
                nt++;
                if (first < 0) first = k;
                if (k % 32 != 0) bad++;
            end
            if (pif.led_out != 8'h00) hi++;
        end
        check("post_rst_first_tick", first, 32);
        check("post_rst_tick_count", nt, 2);
        check("post_rst_tick_spacing", bad, 0);
        check("post_rst_led", hi, 0);

        // Static duty
        pif.fade_en = 1'b0; pif.duty_max = 4'd8; pif.led_in = 8'h01;
        run_period("pre_duty", 0, 0, -1, 8'h00, -1, 8'h00);
        pif.duty_max = 4'd15;
        run_period("duty8", exp_hi(8), 0, -1, 8'h00, -1, 8'h00);
        pif.led_in = 8'h00;
        run_period("duty15", 32, 0, -1, 8'h00, -1, 8'h00);

        // Fade up then down
        pif.fade_en = 1'b1; pif.duty_max = 4'd15; pif.led_in = 8'h81;
        run_period("fade_l0", 0, 0, -1, 8'h00, -1, 8'h00);
        run_period("up4", exp_hi(4), exp_hi(4), -1, 8'h00, -1, 8'h00);
        run_period("up8", exp_hi(8), exp_hi(8), -1, 8'h00, -1, 8'h00);
        pif.led_in = 8'h81;
        run_period("up12", exp_hi(12), exp_hi(12), -1, 8'h00, -1, 8'h00);
        pif.led_in = 8'h00;
        run_period("up15", 32, 32, -1, 8'h00, -1, 8'h00);
        run_period("dn11", exp_hi(11), exp_hi(11), -1, 8'h00, -1, 8'h00);
        run_period("dn7", exp_hi(7), exp_hi(7), -1, 8'h00, -1, 8'h00);
        run_period("dn3", exp_hi(3), exp_hi(3), -1, 8'h00, -1, 8'h00);

        // Mid-period request changes
        pif.fade_en = 1'b0; pif.duty_max = 4'd8; pif.led_in = 8'h01;
        run_period("mid_off", 0, 0, 10, 8'h00, 20, 8'h01);
        run_period("mid_on", exp_hi(8), 0, 12, 8'h00, -1, 8'h00);
        run_period("mid_drop", 0, 0, 31, 8'h01, -1, 8'h00);
        run_period("mid_last", exp_hi(8), 0, -1, 8'h00, -1, 8'h00);

        // Reset in the middle of a lit period
        pif.fade_en = 1'b1; pif.duty_max = 4'd15;
        repeat (4) @(negedge clk);
        check("pre_rst_led0", pif.led_out[0], 1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_led", pif.led_out, 0);
        check("mid_rst_tick", pif.period_tick, 0);
        @(negedge clk);
        reset = 1'b0;

        first = -1; hi = 0;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            if (pif.period_tick && first < 0) first = k;
            if (k < 32 && pif.led_out != 8'h00) hi++;
        end
        check("rerst_first_tick", first, 32);
        check("rerst_dark", hi, 0);
        run_period("rerst_up4", exp_hi(4), 0, -1, 8'h00, -1, 8'h00);
        run_period("rerst_up8", exp_hi(8), 0, -1, 8'h00, -1, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
